lsu_mem_arbiter: RTL and testbench

LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

---
 rtl/lsu_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// Arbitrates one data-memory port between load-queue requests and store-buffer drain.
// Holds at most one transaction in flight. A load killed by flush completes silently.
module lsu_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ROB_WIDTH    = 5,
  parameter int unsigned PHY_WIDTH    = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  input  logic [ADDR_WIDTH-1:0] ld_req_addr,
  input  logic [2:0]            ld_req_funct3,
  input  logic [ROB_WIDTH-1:0]  ld_req_rob_id,
  input  logic [PHY_WIDTH-1:0]  ld_req_rd_phy,
  input  logic                  st_req_valid,
  output logic                  st_req_ready,
  input  logic [ADDR_WIDTH-1:0] st_req_addr,
  input  logic [DATA_WIDTH-1:0] st_req_data,
  input  logic [2:0]            st_req_funct3,
  input  logic                  st_almost_full,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [2:0]            mem_req_funct3,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  ld_resp_valid,
  output logic [DATA_WIDTH-1:0] ld_resp_data,
  output logic [ROB_WIDTH-1:0]  ld_resp_rob_id,
  output logic [PHY_WIDTH-1:0]  ld_resp_rd_phy,
  output logic                  busy
);

  localparam int unsigned CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StWaitResp} state_e;

  state_e                r_state, w_state_d;
  logic [CNT_WIDTH-1:0]  r_starve_cnt, w_starve_cnt_d;
  logic                  r_kill, w_kill_d;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;
  logic [ROB_WIDTH-1:0]  r_rob_id;
  logic [PHY_WIDTH-1:0]  r_rd_phy;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [ROB_WIDTH-1:0]  r_resp_rob_id;
  logic [PHY_WIDTH-1:0]  r_resp_rd_phy;

  logic w_idle, w_in_req, w_st_pri, w_ld_grant, w_st_grant, w_resp_fire;

  assign w_idle      = (r_state == StIdle);
  assign w_in_req    = (r_state == StReq);
  // Store wins outright when the buffer is nearly full or loads have starved it.
  assign w_st_pri    = st_req_valid && (st_almost_full || (r_starve_cnt == CNT_MAX));
  assign w_ld_grant  = w_idle && !w_st_pri && ld_req_valid && !flush;
  assign w_st_grant  = w_idle && st_req_valid && !w_ld_grant;
  assign w_resp_fire = (r_state == StWaitResp) && mem_resp_valid;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (w_ld_grant || w_st_grant) w_state_d = StReq;
      StReq:      if (mem_req_ready) w_state_d = r_we ? StIdle : StWaitResp;
      StWaitResp: if (mem_resp_valid) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_kill_d = r_kill;
    if (w_state_d == StIdle) begin
      w_kill_d = 1'b0;
    end else if (flush && !w_idle && !r_we) begin
      w_kill_d = 1'b1;
    end
  end

  always_comb begin
    w_starve_cnt_d = r_starve_cnt;
    if (w_st_grant) begin
      w_starve_cnt_d = '0;
    end else if (w_ld_grant && st_req_valid && (r_starve_cnt != CNT_MAX)) begin
      w_starve_cnt_d = r_starve_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_starve_cnt  <= '0;
      r_kill        <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_funct3      <= '0;
      r_rob_id      <= '0;
      r_rd_phy      <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_rob_id <= '0;
      r_resp_rd_phy <= '0;
    end else begin
      r_state      <= w_state_d;
      r_starve_cnt <= w_starve_cnt_d;
      r_kill       <= w_kill_d;
      if (w_ld_grant) begin
        r_we     <= 1'b0;
        r_addr   <= ld_req_addr;
        r_wdata  <= '0;
        r_funct3 <= ld_req_funct3;
        r_rob_id <= ld_req_rob_id;
        r_rd_phy <= ld_req_rd_phy;
      end else if (w_st_grant) begin
        r_we     <= 1'b1;
        r_addr   <= st_req_addr;
        r_wdata  <= st_req_data;
        r_funct3 <= st_req_funct3;
      end
      // A flush arriving with the response still kills the writeback.
      r_resp_valid <= w_resp_fire && !r_kill && !flush;
      if (w_resp_fire) begin
        r_resp_data   <= mem_resp_rdata;
        r_resp_rob_id <= r_rob_id;
        r_resp_rd_phy <= r_rd_phy;
      end
    end
  end

  // Ready is masked by rst_n so nothing is accepted while reset is held.
  assign ld_req_ready   = w_ld_grant && rst_n;
  assign st_req_ready   = w_st_grant && rst_n;
  assign mem_req_valid  = w_in_req;
  assign mem_req_we     = w_in_req && r_we;
  assign mem_req_addr   = w_in_req ? r_addr : '0;
  assign mem_req_wdata  = w_in_req ? r_wdata : '0;
  assign mem_req_funct3 = w_in_req ? r_funct3 : '0;
  assign ld_resp_valid  = r_resp_valid;
  assign ld_resp_data   = r_resp_data;
  assign ld_resp_rob_id = r_resp_rob_id;
  assign ld_resp_rd_phy = r_resp_rd_phy;
  assign busy           = !w_idle;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard bench for lsu_mem_arbiter: expectations are queued at grant time
// and popped when the memory request or load writeback appears.
module tb_lsu_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_req_valid, ld_req_ready;
  logic [AW-1:0] ld_req_addr;
  logic [2:0]    ld_req_funct3;
  logic [RW-1:0] ld_req_rob_id;
  logic [PW-1:0] ld_req_rd_phy;
  logic          st_req_valid, st_req_ready;
  logic [AW-1:0] st_req_addr;
  logic [DW-1:0] st_req_data;
  logic [2:0]    st_req_funct3;
  logic          st_almost_full, flush;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [2:0]    mem_req_funct3;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic          ld_resp_valid;
  logic [DW-1:0] ld_resp_data;
  logic [RW-1:0] ld_resp_rob_id;
  logic [PW-1:0] ld_resp_rd_phy;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Load writeback scoreboard
  logic [DW-1:0] exp_data_q[$];
  logic [RW-1:0] exp_rob_q[$];
  logic [PW-1:0] exp_phy_q[$];
  // Memory request scoreboard
  logic [AW-1:0] exp_addr_q[$];
  logic          exp_we_q[$];
  logic [DW-1:0] exp_wdata_q[$];

  always #5 clk = ~clk;

  lsu_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROB_WIDTH(RW), .PHY_WIDTH(PW), .STARVE_LIMIT(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
    .ld_req_funct3(ld_req_funct3), .ld_req_rob_id(ld_req_rob_id),
    .ld_req_rd_phy(ld_req_rd_phy),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_req_funct3(st_req_funct3),
    .st_almost_full(st_almost_full), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_funct3(mem_req_funct3),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .ld_resp_rob_id(ld_resp_rob_id), .ld_resp_rd_phy(ld_resp_rd_phy),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ld_req_valid = 0; ld_req_addr = '0; ld_req_funct3 = '0; ld_req_rob_id = '0;
    ld_req_rd_phy = '0; st_req_valid = 0; st_req_addr = '0; st_req_data = '0;
    st_req_funct3 = '0; st_almost_full = 0; flush = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_rdata = '0;
  endtask

  task automatic push_load(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [RW-1:0] r, input logic [PW-1:0] p);
    exp_addr_q.push_back(a); exp_we_q.push_back(1'b0); exp_wdata_q.push_back('0);
    exp_data_q.push_back(d); exp_rob_q.push_back(r); exp_phy_q.push_back(p);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0; ld_req_valid = 1; st_req_valid = 1; st_almost_full = 1; mem_resp_valid = 1;
    tick(); tick();
    n_tests++;
    if ({ld_req_ready, st_req_ready, mem_req_valid, mem_req_we, busy, ld_resp_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {ld_req_ready, st_req_ready, mem_req_valid, mem_req_we, busy, ld_resp_valid});
    end
    n_tests++;
    if ({mem_req_addr, mem_req_wdata, ld_resp_data, ld_resp_rob_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h rob %h want all 0",
               mem_req_addr, mem_req_wdata, ld_resp_data, ld_resp_rob_id);
    end
    clear_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_basic();
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd, d; logic [RW-1:0] r; logic [PW-1:0] p;
    clear_inputs();
    mem_req_ready = 1;
    ld_req_valid = 1; ld_req_addr = 32'h100; ld_req_rob_id = 5'd3; ld_req_rd_phy = 6'd9;
    ld_req_funct3 = 3'b010;
    #1;
    n_tests++;
    if ({ld_req_ready, st_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL load_grant: ld/st ready %b want 10", {ld_req_ready, st_req_ready});
    end
    push_load(32'h100, 32'hDEADBEEF, 5'd3, 6'd9);
    tick();  // T+1
    ld_req_valid = 0;
    n_tests++;
    if (exp_addr_q.size() == 0) begin
      n_fail++; $display("FAIL load_mem_req: scoreboard empty");
    end else begin
      a = exp_addr_q.pop_front(); w = exp_we_q.pop_front(); wd = exp_wdata_q.pop_front();
      if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== {1'b1, w, a, wd}) begin
        n_fail++;
        $display("FAIL load_mem_req: v %b we %b addr %h wdata %h want 1 %b %h %h",
                 mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, w, a, wd);
      end
    end
    tick();  // T+2
    mem_resp_valid = 1; mem_resp_rdata = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (ld_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_early_resp: ld_resp_valid %b want 0", ld_resp_valid);
    end
    tick();  // T+3
    mem_resp_valid = 0;
    n_tests++;
    if (ld_resp_valid !== 1'b1 || exp_data_q.size() == 0) begin
      n_fail++; $display("FAIL load_resp_t3: ld_resp_valid %b want 1", ld_resp_valid);
    end else begin
      d = exp_data_q.pop_front(); r = exp_rob_q.pop_front(); p = exp_phy_q.pop_front();
      if ({ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy} !== {d, r, p}) begin
        n_fail++;
        $display("FAIL load_resp_fields: data %h rob %0d phy %0d want %h %0d %0d",
                 ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy, d, r, p);
      end
    end
    tick();  // T+4
    n_tests++;
    if ({ld_resp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL load_pulse_end: valid/busy %b want 00", {ld_resp_valid, busy});
    end
  endtask

  task automatic test_store_priority();
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd;
    clear_inputs();
    mem_req_ready = 1;
    ld_req_valid = 1; ld_req_addr = 32'h300;
    st_req_valid = 1; st_almost_full = 1; st_req_addr = 32'h200; st_req_data = 32'h12345678;
    st_req_funct3 = 3'b010;
    #1;
    n_tests++;
    if ({st_req_ready, ld_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL st_prio_grant: st/ld ready %b want 10", {st_req_ready, ld_req_ready});
    end
    exp_addr_q.push_back(32'h200); exp_we_q.push_back(1'b1); exp_wdata_q.push_back(32'h12345678);
    tick();
    clear_inputs();
    mem_req_ready = 1;
    n_tests++;
    a = exp_addr_q.pop_front(); w = exp_we_q.pop_front(); wd = exp_wdata_q.pop_front();
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== {1'b1, w, a, wd}) begin
      n_fail++;
      $display("FAIL st_prio_mem_req: v %b we %b addr %h wdata %h want 1 %b %h %h",
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, w, a, wd);
    end
    tick();
    n_tests++;
    if ({busy, mem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL st_prio_idle: busy/mem_v %b want 00", {busy, mem_req_valid});
    end
  endtask

  task automatic test_starvation();
    bit            exp_grant_q[$];  // 0 = load, 1 = store
    logic [9:0]    pat;
    bit            resp_due;
    bit            g, e;
    clear_inputs();
    pat = 10'b1000010000;
    for (int i = 0; i < 10; i++) exp_grant_q.push_back(pat[i]);
    mem_req_ready = 1; ld_req_valid = 1; st_req_valid = 1;
    ld_req_addr = 32'h40; st_req_addr = 32'h80; st_req_data = 32'h5;
    resp_due = 0;
    for (int cyc = 0; cyc < 100 && exp_grant_q.size() > 0; cyc++) begin
      mem_resp_valid = resp_due; mem_resp_rdata = 32'(cyc);
      #1;
      if (ld_req_ready || st_req_ready) begin
        g = st_req_ready;
        e = exp_grant_q.pop_front();
        n_tests++;
        if (g !== e || (ld_req_ready && st_req_ready)) begin
          n_fail++;
          $display("FAIL starve_seq: grant ld %b st %b want %s",
                   ld_req_ready, st_req_ready, e ? "store" : "load");
        end
      end
      resp_due = mem_req_valid && !mem_req_we;
      tick();
    end
    n_tests++;
    if (exp_grant_q.size() != 0) begin
      n_fail++; $display("FAIL starve_timeout: %0d grants missing want 0", exp_grant_q.size());
    end
    ld_req_valid = 0; st_req_valid = 0;
    for (int cyc = 0; cyc < 10 && busy; cyc++) begin
      mem_resp_valid = resp_due;
      resp_due = mem_req_valid && !mem_req_we;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_idle();
    clear_inputs();
    ld_req_valid = 1; flush = 1;
    #1;
    n_tests++;
    if (ld_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_ld: ld_req_ready %b want 0", ld_req_ready);
    end
    st_req_valid = 1; st_req_addr = 32'h900; st_req_data = 32'hA5A5;
    #1;
    n_tests++;
    if ({st_req_ready, ld_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL flush_idle_st: st/ld ready %b want 10", {st_req_ready, ld_req_ready});
    end
    tick();
    clear_inputs();
    flush = 1; mem_req_ready = 1;
    n_tests++;
    if ({mem_req_valid, mem_req_we, mem_req_addr} !== {2'b11, 32'h900}) begin
      n_fail++; $display("FAIL flush_store_req: v %b we %b addr %h want 1 1 900",
                         mem_req_valid, mem_req_we, mem_req_addr);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush_wait();
    logic [DW-1:0] d; logic [RW-1:0] r; logic [PW-1:0] p;
    clear_inputs();
    mem_req_ready = 1;
    ld_req_valid = 1; ld_req_addr = 32'h400; ld_req_rob_id = 5'd5; ld_req_rd_phy = 6'd1;
    tick();  // REQ
    ld_req_valid = 0;
    tick();  // WAIT_RESP
    flush = 1;
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_wait_busy: busy %b want 1", busy);
    end
    tick();
    flush = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0BAD0;
    tick();
    mem_resp_valid = 0;
    n_tests++;
    if ({ld_resp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL flush_killed: valid/busy %b want 00", {ld_resp_valid, busy});
    end
    mem_resp_valid = 1;  // stray response while idle
    tick();
    mem_resp_valid = 0;
    n_tests++;
    if ({ld_resp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL stray_resp: valid/busy %b want 00", {ld_resp_valid, busy});
    end
    ld_req_valid = 1; ld_req_addr = 32'h404; ld_req_rob_id = 5'd6; ld_req_rd_phy = 6'd2;
    #1;
    push_load(32'h404, 32'hCAFEF00D, 5'd6, 6'd2);
    void'(exp_addr_q.pop_front()); void'(exp_we_q.pop_front()); void'(exp_wdata_q.pop_front());
    tick();
    ld_req_valid = 0;
    tick();
    mem_resp_valid = 1; mem_resp_rdata = 32'hCAFEF00D;
    tick();
    mem_resp_valid = 0;
    n_tests++;
    if (ld_resp_valid !== 1'b1 || exp_data_q.size() == 0) begin
      n_fail++; $display("FAIL flush_next_load: ld_resp_valid %b want 1", ld_resp_valid);
    end else begin
      d = exp_data_q.pop_front(); r = exp_rob_q.pop_front(); p = exp_phy_q.pop_front();
      if ({ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy} !== {d, r, p}) begin
        n_fail++;
        $display("FAIL flush_next_fields: data %h rob %0d phy %0d want %h %0d %0d",
                 ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy, d, r, p);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    logic [DW-1:0] d; logic [RW-1:0] r; logic [PW-1:0] p;
    clear_inputs();
    ld_req_valid = 1; ld_req_addr = 32'h500; ld_req_rob_id = 5'd7; ld_req_rd_phy = 6'd3;
    ld_req_funct3 = 3'b001;
    #1;
    push_load(32'h500, 32'h55AA55AA, 5'd7, 6'd3);
    void'(exp_addr_q.pop_front()); void'(exp_we_q.pop_front()); void'(exp_wdata_q.pop_front());
    tick();
    st_req_valid = 1; st_req_addr = 32'h600; ld_req_addr = 32'h504;
    for (int i = 0; i < 6; i++) begin
      mem_req_ready = (i == 5);
      #1;
      n_tests++;
      if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_funct3, ld_req_ready, st_req_ready}
          !== {2'b10, 32'h500, 3'b001, 2'b00}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v %b we %b addr %h f3 %b ldr %b str %b want 1 0 500 001 0 0",
                 i, mem_req_valid, mem_req_we, mem_req_addr, mem_req_funct3,
                 ld_req_ready, st_req_ready);
      end
      tick();
    end
    ld_req_valid = 0; st_req_valid = 0; mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_rdata = 32'h55AA55AA;
    tick();
    mem_resp_valid = 0;
    n_tests++;
    if (ld_resp_valid !== 1'b1 || exp_data_q.size() == 0) begin
      n_fail++; $display("FAIL stall_resp: ld_resp_valid %b want 1", ld_resp_valid);
    end else begin
      d = exp_data_q.pop_front(); r = exp_rob_q.pop_front(); p = exp_phy_q.pop_front();
      if ({ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy} !== {d, r, p}) begin
        n_fail++;
        $display("FAIL stall_fields: data %h rob %0d phy %0d want %h %0d %0d",
                 ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy, d, r, p);
      end
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    clear_inputs();
    mem_req_ready = 1;
    ld_req_valid = 1; ld_req_addr = 32'h700; ld_req_rob_id = 5'd9; ld_req_rd_phy = 6'd4;
    tick();
    ld_req_valid = 0;
    tick();  // WAIT_RESP
    ld_req_valid = 1; rst_n = 0;
    #1;
    n_tests++;
    if ({ld_req_ready, st_req_ready, mem_req_valid, busy, ld_resp_valid} !== 5'b0 ||
        {ld_resp_data, ld_resp_rob_id, mem_req_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: ldr %b str %b mv %b busy %b rv %b rdata %h rob %0d want all 0",
               ld_req_ready, st_req_ready, mem_req_valid, busy, ld_resp_valid,
               ld_resp_data, ld_resp_rob_id);
    end
    tick();
    rst_n = 1; mem_resp_valid = 1; mem_resp_rdata = 32'hBAD;
    ld_req_addr = 32'h708; ld_req_rob_id = 5'd10; ld_req_rd_phy = 6'd5;
    #1;
    n_tests++;
    if (ld_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_grant: ld_req_ready %b want 1", ld_req_ready);
    end
    tick();
    ld_req_valid = 0; mem_resp_valid = 0;
    n_tests++;
    if ({ld_resp_valid, mem_req_valid, mem_req_addr} !== {2'b01, 32'h708}) begin
      n_fail++; $display("FAIL reset_late_resp: rv %b mv %b addr %h want 0 1 708",
                         ld_resp_valid, mem_req_valid, mem_req_addr);
    end
    tick();
    mem_resp_valid = 1; mem_resp_rdata = 32'h0F0F0F0F;
    tick();
    mem_resp_valid = 0;
    n_tests++;
    if ({ld_resp_valid, ld_resp_data, ld_resp_rob_id} !== {1'b1, 32'h0F0F0F0F, 5'd10}) begin
      n_fail++; $display("FAIL reset_next_load: rv %b data %h rob %0d want 1 0f0f0f0f 10",
                         ld_resp_valid, ld_resp_data, ld_resp_rob_id);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_store_priority();
    test_starvation();
    test_flush_idle();
    test_flush_wait();
    test_stall();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
